// File: rtl/adc_spi_reader_if.sv
// adc_spi_reader_if: bus between the ADC SPI reader and its neighbours.
// Signals: start/miso into the reader; sclk, cs_n, rxData, spiReceived, busy out of it.
// With ADC_OVERRUN_EN defined, an extra sticky overrun flag is carried.
interface adc_spi_reader_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              miso;
  logic              sclk;
  logic              cs_n;
  logic [DATA_W-1:0] rxData;
  logic              spiReceived;
  logic              busy;
`ifdef ADC_OVERRUN_EN
  logic              overrun;
  modport master (input start, miso, output sclk, cs_n, rxData, spiReceived, busy, overrun);
  modport slave (output start, miso, input sclk, cs_n, rxData, spiReceived, busy, overrun);
`else
  modport master (input start, miso, output sclk, cs_n, rxData, spiReceived, busy);
  modport slave (output start, miso, input sclk, cs_n, rxData, spiReceived, busy);
`endif
endinterface

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI master that waits for mux settle, then clocks in one ADC word per start.
// Ports: clk, reset (async, active-low), bus (adc_spi_reader_if.master):
//   start in, miso in, sclk out (CPOL=0/CPHA=0), cs_n out, rxData out,
//   spiReceived out (RX_HOLD-cycle strobe), busy out.
// Optional: define ADC_OVERRUN_EN to add bus.overrun, a sticky flag set by a start while busy.
module adc_spi_reader #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int SETTLE  = 8,
  parameter int RX_HOLD = 4
) (
  input logic              clk,
  input logic              reset,
  adc_spi_reader_if.master bus
);
  localparam int LIM_A = SETTLE > CLK_DIV ? SETTLE : CLK_DIV;
  localparam int LIM   = LIM_A > RX_HOLD ? LIM_A : RX_HOLD;
  localparam int CW    = $clog2(LIM + 1);
  localparam int BW    = $clog2(DATA_W);
  typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_CS_SETUP, ST_SHIFT, ST_HOLD} state_t;
  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n, lim;
  logic [BW-1:0]     bitc, bitc_n;
  logic [DATA_W-1:0] sh, sh_n, rx, rx_n;
  logic              sclk, sclk_n, cs_n, cs_n_n, rcv, rcv_n, busy, done;
  // one counter times every phase; its terminal value depends on the phase
  assign lim  = state == ST_SETTLE ? CW'(SETTLE - 1) :
                state == ST_HOLD   ? CW'(RX_HOLD - 1) : CW'(CLK_DIV - 1);
  assign done = cnt == lim;
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    bitc_n  = bitc;
    sclk_n  = sclk;
    cs_n_n  = cs_n;
    sh_n    = sh;
    rx_n    = rx;
    rcv_n   = rcv;
    case (state)
      ST_IDLE: state_n = bus.start ? ST_SETTLE : ST_IDLE;
      ST_SETTLE:
        if (done) begin
          state_n = ST_CS_SETUP;
          cs_n_n  = 1'b0;
        end else cnt_n = cnt + 1'b1;
      ST_CS_SETUP:
        if (done) begin
          // first sclk rise samples the first (MSB) bit
          state_n = ST_SHIFT;
          sclk_n  = 1'b1;
          sh_n    = {sh[DATA_W-2:0], bus.miso};
          bitc_n  = '0;
        end else cnt_n = cnt + 1'b1;
      ST_SHIFT:
        if (!done) cnt_n = cnt + 1'b1;
        else if (sclk) sclk_n = 1'b0;
        else if (bitc == BW'(DATA_W - 1)) begin
          state_n = ST_HOLD;
          cs_n_n  = 1'b1;
          rx_n    = sh;
          rcv_n   = 1'b1;
        end else begin
          sclk_n = 1'b1;
          sh_n   = {sh[DATA_W-2:0], bus.miso};
          bitc_n = bitc + 1'b1;
        end
      ST_HOLD:
        if (done) begin
          state_n = ST_IDLE;
          rcv_n   = 1'b0;
        end else cnt_n = cnt + 1'b1;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      bitc  <= '0;
      sclk  <= 1'b0;
      cs_n  <= 1'b1;
      sh    <= '0;
      rx    <= '0;
      rcv   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitc  <= bitc_n;
      sclk  <= sclk_n;
      cs_n  <= cs_n_n;
      sh    <= sh_n;
      rx    <= rx_n;
      rcv   <= rcv_n;
      busy  <= state_n != ST_IDLE;
    end
`ifdef ADC_OVERRUN_EN
  logic ovr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) ovr <= 1'b0;
    else ovr <= ovr | (bus.start & busy);
  assign bus.overrun = ovr;
`endif
  assign bus.sclk        = sclk;
  assign bus.cs_n        = cs_n;
  assign bus.rxData      = rx;
  assign bus.spiReceived = rcv;
  assign bus.busy        = busy;
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: directed + random conversions on a default and a minimum-parameter reader.
module tb_adc_spi_reader;
  localparam int SA = 8, DA = 4, HA = 4, WA = 16, LAT_A = SA + DA + 2 * DA * WA;
  localparam int SB = 1, DB = 1, HB = 2, WB = 8, LAT_B = SB + DB + 2 * DB * WB;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  adc_spi_reader_if #(.DATA_W(WA)) ifa ();
  adc_spi_reader_if #(.DATA_W(WB)) ifb ();
  adc_spi_reader #(.DATA_W(WA), .CLK_DIV(DA), .SETTLE(SA), .RX_HOLD(HA)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  adc_spi_reader #(.DATA_W(WB), .CLK_DIV(DB), .SETTLE(SB), .RX_HOLD(HB)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  always #5 clk = ~clk;
  // ADC models: present the word MSB first, advancing one bit on each sclk falling edge
  logic [WA-1:0] word_a = '0, sh_a, exp_a = '0;
  logic [WB-1:0] word_b = '0, sh_b, exp_b = '0;
  int falls_a = 0, base_a = 0, rises_a = 0, pulses_a = 0;
  int falls_b = 0, base_b = 0, rises_b = 0, pulses_b = 0;
  logic exp_ovr_a = 1'b0;
  always @(negedge ifa.sclk) falls_a++;
  always @(negedge ifb.sclk) falls_b++;
  always @(posedge ifa.sclk) rises_a++;
  always @(posedge ifb.sclk) rises_b++;
  always @(posedge ifa.spiReceived) pulses_a++;
  always @(posedge ifb.spiReceived) pulses_b++;
  assign sh_a     = word_a << (falls_a - base_a);
  assign sh_b     = word_b << (falls_b - base_b);
  assign ifa.miso = sh_a[WA-1];
  assign ifb.miso = sh_b[WB-1];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  // call just after a negedge; leaves the caller at the negedge where the FSM is back in IDLE
  task automatic conv_a(input logic [WA-1:0] w, input int e1, input int e2);
    int rise, hi, cs_bad, r0, p0;
    rise = -1; hi = 0; cs_bad = 0; r0 = rises_a; p0 = pulses_a;
    word_a = w; base_a = falls_a;
    ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = (e1 == 1 || e2 == 1);
    check("a_busy_rise", 32'(ifa.busy), 32'd1);
    for (int n = 1; n <= LAT_A + HA; n++) begin
      @(negedge clk);
      ifa.start = (n + 1 == e1 || n + 1 == e2);
      if (ifa.spiReceived && rise < 0) rise = n;
      hi += int'(ifa.spiReceived);
      cs_bad += int'(ifa.cs_n !== (n < SA || n >= LAT_A));
      if (n == LAT_A - 1) check("a_rx_before_done", 32'(ifa.rxData), 32'(exp_a));
    end
    exp_a = w;
    if (e1 != 0 || e2 != 0) exp_ovr_a = 1'b1;
    check("a_latency", rise, LAT_A);
    check("a_strobe_len", hi, HA);
    check("a_sclk_rises", rises_a - r0, WA);
    check("a_strobe_count", pulses_a - p0, 1);
    check("a_cs_window", cs_bad, 0);
    check("a_rxdata", 32'(ifa.rxData), 32'(exp_a));
    check("a_busy_fall", 32'(ifa.busy), 32'd0);
`ifdef ADC_OVERRUN_EN
    check("a_overrun", 32'(ifa.overrun), 32'(exp_ovr_a));
`endif
  endtask
  task automatic conv_b(input logic [WB-1:0] w);
    int rise, hi, cs_bad, r0;
    rise = -1; hi = 0; cs_bad = 0; r0 = rises_b;
    word_b = w; base_b = falls_b;
    ifb.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifb.start = 1'b0;
    for (int n = 1; n <= LAT_B + HB; n++) begin
      @(negedge clk);
      if (ifb.spiReceived && rise < 0) rise = n;
      hi += int'(ifb.spiReceived);
      cs_bad += int'(ifb.cs_n !== (n < SB || n >= LAT_B));
      if (n == LAT_B - 1) check("b_rx_before_done", 32'(ifb.rxData), 32'(exp_b));
    end
    exp_b = w;
    check("b_latency", rise, LAT_B);
    check("b_strobe_len", hi, HB);
    check("b_sclk_rises", rises_b - r0, WB);
    check("b_cs_window", cs_bad, 0);
    check("b_rxdata", 32'(ifb.rxData), 32'(exp_b));
    check("b_busy_fall", 32'(ifb.busy), 32'd0);
  endtask
  task automatic check_reset_a(input string tag);
    check({tag, "_sclk"}, 32'(ifa.sclk), 32'd0);
    check({tag, "_cs_n"}, 32'(ifa.cs_n), 32'd1);
    check({tag, "_rxdata"}, 32'(ifa.rxData), 32'd0);
    check({tag, "_strobe"}, 32'(ifa.spiReceived), 32'd0);
    check({tag, "_busy"}, 32'(ifa.busy), 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;
    int r0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_a("por");
    check("por_b_busy", 32'(ifb.busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    r0 = rises_a;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(ifa.busy), 32'd0);
    check("idle_no_sclk", rises_a - r0, 0);
    conv_a(16'hA5C3, 0, 0);
    conv_a(16'h0001, 0, 0);
    conv_a(16'hFFFF, 0, 0);
    ra = WA'($urandom);
    conv_a(ra, 50, 139);
    repeat (3) begin
      ra = WA'($urandom);
      conv_a(ra, 0, 0);
    end
    // abort during bit 7 of the shift phase
    word_a = 16'h5A5A; base_a = falls_a;
    ifa.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (70) @(negedge clk);
    check("abort_in_shift", 32'(ifa.cs_n), 32'd0);
    reset = 1'b0;
    #1 check_reset_a("abort");
    exp_a = '0;
    exp_b = '0;
    exp_ovr_a = 1'b0;
`ifdef ADC_OVERRUN_EN
    check("abort_overrun", 32'(ifa.overrun), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    r0 = rises_a;
    repeat (10) @(negedge clk);
    check("post_abort_busy", 32'(ifa.busy), 32'd0);
    check("post_abort_rxdata", 32'(ifa.rxData), 32'd0);
    check("post_abort_no_sclk", rises_a - r0, 0);
    conv_a(16'h1234, 0, 0);
    conv_b(8'h81);
    repeat (3) begin
      rb = WB'($urandom);
      conv_b(rb);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
